score_lives_keeper: RTL and testbench

- Sits directly downstream of the collision/game-control stage. Consumes its per-shot rock-hit vector and ship-collision level.
- Collision inputs are combinational and may stay high for many cycles. This block latches them once per video frame.
- Per frame it converts the latched hits into BCD score increments and life losses, runs the game-mode FSM and times respawn invulnerability.
- Outputs drive the HUD/hex display and gate ship rendering and control.

---
 rtl/game_pkg.sv | 16 +
 rtl/bcd_add_sat.sv | 35 +++
 rtl/score_lives_keeper.sv | 154 +++++++++++++++
 tb/tb_score_lives_keeper.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the score/lives keeper and its BCD adder.
package game_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, RESPAWN, OVER} state_t;

  typedef logic [15:0] bcd4_t;

  localparam int    SCORE_W = 16;
  localparam int    PEND_W  = 4;
  localparam bcd4_t BCD_MAX = 16'h9999;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/bcd_add_sat.sv
// Four-digit BCD add of a single-digit constant, clamped to 9999 on overflow.
module bcd_add_sat
  import game_pkg::*;
#(
  parameter logic [3:0] ADDEND = 4'd5
) (
  input  bcd4_t a_i,
  output bcd4_t sum_o
);

  localparam int NDIG = SCORE_W / 4;

  logic [4:0] carry;
  logic [4:0] tmp;
  bcd4_t      sum;

  always_comb begin
    sum   = '0;
    tmp   = '0;
    carry = {1'b0, ADDEND};
    for (int d = 0; d < NDIG; d++) begin
      tmp = {1'b0, a_i[d*4 +: 4]} + carry;
      if (tmp > 5'd9) begin
        sum[d*4 +: 4] = 4'(tmp - 5'd10);
        carry         = 5'd1;
      end else begin
        sum[d*4 +: 4] = tmp[3:0];
        carry         = 5'd0;
      end
    end
    // A carry out of the top digit means the true sum passed 9999.
    sum_o = (carry != 5'd0) ? BCD_MAX : sum;
  end

endmodule

// File: rtl/score_lives_keeper.sv
// Per-frame score and lives bookkeeping: latches collision levels once per
// frame, drains rock hits into a BCD score and sequences game mode/respawn.
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   PLAY    | ship live, collisions cost a life
//   RESPAWN | ship invulnerable for INVULN_FRAMES ticks
//   OVER    | lives exhausted, score frozen, waiting for start
module score_lives_keeper
  import game_pkg::*;
#(
  parameter int START_LIVES     = 3,
  parameter int POINTS_PER_ROCK = 5,
  parameter int INVULN_FRAMES   = 120
) (
  input  logic       Clk,
  input  logic       Reset_h,
  input  logic       vs,
  input  logic       start,
  input  logic [3:0] shot_hits,
  input  logic       ship_hit,
  output bcd4_t      score_bcd,
  output logic [2:0] lives,
  output logic       in_play,
  output logic       game_over,
  output logic       ship_invuln,
  output logic       ship_blink,
  output logic       life_lost
);

  localparam logic [2:0] LIVES_INIT  = 3'(START_LIVES);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);

  state_t              state_q;
  logic                vs_q1, vs_q2;
  logic                tick, capture, restart, add_en;
  bcd4_t               score_q, score_d, add_sum;
  logic [2:0]          lives_q;
  logic [3:0]          hit_sticky_q, hit_sticky_d;
  logic                ship_sticky_q, ship_sticky_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic [PEND_W:0]     pend_sum;
  logic [7:0]          frame_cnt_q;
  logic                life_lost_q, in_play_q, game_over_q, ship_invuln_q;

  assign tick    = vs_q1 & ~vs_q2;
  assign capture = (state_q == PLAY) || (state_q == RESPAWN);
  assign restart = (state_q == OVER) && start;
  assign add_en  = (pending_q != '0);

  bcd_add_sat #(
    .ADDEND(4'(POINTS_PER_ROCK))
  ) u_add (
    .a_i  (score_q),
    .sum_o(add_sum)
  );

  always_comb begin
    hit_sticky_d  = '0;
    ship_sticky_d = 1'b0;
    if (capture) begin
      hit_sticky_d  = (tick ? 4'b0000 : hit_sticky_q) | shot_hits;
      ship_sticky_d = (tick ? 1'b0 : ship_sticky_q) | ship_hit;
    end

    // Drain one add and fold in the new frame's hits in the same cycle.
    pend_sum = {1'b0, pending_q} - {{PEND_W{1'b0}}, add_en}
             + (tick ? {{(PEND_W-2){1'b0}}, popcount4(hit_sticky_q)} : '0);
    pending_d = pend_sum[PEND_W] ? '1 : pend_sum[PEND_W-1:0];

    score_d = score_q;
    if (restart) begin
      pending_d = '0;
      score_d   = '0;
    end else if (add_en) begin
      score_d = add_sum;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state_q       <= IDLE;
      vs_q1         <= 1'b0;
      vs_q2         <= 1'b0;
      score_q       <= '0;
      lives_q       <= LIVES_INIT;
      hit_sticky_q  <= '0;
      ship_sticky_q <= 1'b0;
      pending_q     <= '0;
      frame_cnt_q   <= '0;
      life_lost_q   <= 1'b0;
      in_play_q     <= 1'b0;
      game_over_q   <= 1'b0;
      ship_invuln_q <= 1'b0;
    end else begin
      vs_q1         <= vs;
      vs_q2         <= vs_q1;
      score_q       <= score_d;
      hit_sticky_q  <= hit_sticky_d;
      ship_sticky_q <= ship_sticky_d;
      pending_q     <= pending_d;
      life_lost_q   <= 1'b0;
      if (tick) frame_cnt_q <= frame_cnt_q + 8'd1;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= PLAY;
            lives_q   <= LIVES_INIT;
            in_play_q <= 1'b1;
          end
        end
        PLAY: begin
          if (tick && ship_sticky_q) begin
            lives_q     <= lives_q - 3'd1;
            life_lost_q <= 1'b1;
            if (lives_q == 3'd1) begin
              state_q     <= OVER;
              in_play_q   <= 1'b0;
              game_over_q <= 1'b1;
            end else begin
              state_q       <= RESPAWN;
              frame_cnt_q   <= '0;
              ship_invuln_q <= 1'b1;
            end
          end
        end
        RESPAWN: begin
          if (tick && (frame_cnt_q == INVULN_LAST)) begin
            state_q       <= PLAY;
            ship_invuln_q <= 1'b0;
          end
        end
        OVER: begin
          if (start) begin
            state_q     <= PLAY;
            lives_q     <= LIVES_INIT;
            in_play_q   <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign score_bcd   = score_q;
  assign lives       = lives_q;
  assign in_play     = in_play_q;
  assign game_over   = game_over_q;
  assign ship_invuln = ship_invuln_q;
  assign ship_blink  = ship_invuln_q & frame_cnt_q[3];
  assign life_lost   = life_lost_q;

endmodule

// File: tb/tb_score_lives_keeper.sv
// Directed bench for score_lives_keeper: scoring, lives, respawn, saturation, reset.
module tb_score_lives_keeper;
  import game_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_h, vs, start, ship_hit;
  logic [3:0]  shot_hits;
  logic [15:0] score_bcd;
  logic [2:0]  lives;
  logic        in_play, game_over, ship_invuln, ship_blink, life_lost;

  int checks = 0;
  int errors = 0;

  score_lives_keeper dut (
    .Clk        (Clk),
    .Reset_h    (Reset_h),
    .vs         (vs),
    .start      (start),
    .shot_hits  (shot_hits),
    .ship_hit   (ship_hit),
    .score_bcd  (score_bcd),
    .lives      (lives),
    .in_play    (in_play),
    .game_over  (game_over),
    .ship_invuln(ship_invuln),
    .ship_blink (ship_blink),
    .life_lost  (life_lost)
  );

  always #5 Clk = ~Clk;

  // Hits/ship for one cycle, then a vs pulse; 8 cycles after the rise leaves room to drain 4 adds.
  task automatic tick_frame(input logic [3:0] hits, input logic ship);
    @(negedge Clk); shot_hits = hits; ship_hit = ship;
    @(negedge Clk); shot_hits = 4'b0000; ship_hit = 1'b0; vs = 1'b1;
    repeat (4) @(negedge Clk);
    vs = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic pulse_start();
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
  endtask

  task automatic test_reset();
    Reset_h = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (score_bcd !== 16'h0000) begin errors++; $display("FAIL reset_score got %h want %h", score_bcd, 16'h0000); end
    checks++;
    if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d want %0d", lives, 3); end
    checks++;
    if ({in_play, game_over, ship_invuln, ship_blink, life_lost} !== 5'b00000) begin
      errors++; $display("FAIL reset_flags got %b want %b", {in_play, game_over, ship_invuln, ship_blink, life_lost}, 5'b00000);
    end
    Reset_h = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_start();
    pulse_start();
    checks++;
    if ({in_play, game_over} !== 2'b10) begin errors++; $display("FAIL start_play got %b want %b", {in_play, game_over}, 2'b10); end
    checks++;
    if (lives !== 3'd3 || score_bcd !== 16'h0000) begin
      errors++; $display("FAIL start_vals got lives %0d score %h want lives 3 score 0000", lives, score_bcd);
    end
  endtask

  task automatic test_score_hold();
    @(negedge Clk); shot_hits = 4'b0101;
    repeat (500) @(negedge Clk);
    shot_hits = 4'b0000; vs = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (score_bcd !== 16'h0005) begin errors++; $display("FAIL score_3clk got %h want %h", score_bcd, 16'h0005); end
    @(negedge Clk);
    checks++;
    if (score_bcd !== 16'h0010) begin errors++; $display("FAIL score_4clk got %h want %h", score_bcd, 16'h0010); end
    vs = 1'b0;
    repeat (4) @(negedge Clk);
    checks++;
    if (score_bcd !== 16'h0010) begin errors++; $display("FAIL score_settled got %h want %h", score_bcd, 16'h0010); end
  endtask

  task automatic test_life_loss();
    @(negedge Clk); ship_hit = 1'b1;
    @(negedge Clk); ship_hit = 1'b0; vs = 1'b1;
    @(negedge Clk);
    checks++;
    if (life_lost !== 1'b0 || lives !== 3'd3) begin errors++; $display("FAIL life_early got pulse %b lives %0d want 0 3", life_lost, lives); end
    @(negedge Clk);
    checks++;
    if ({life_lost, ship_invuln, ship_blink} !== 3'b110 || lives !== 3'd2) begin
      errors++; $display("FAIL life_pulse got flags %b lives %0d want 110 2", {life_lost, ship_invuln, ship_blink}, lives);
    end
    @(negedge Clk);
    checks++;
    if (life_lost !== 1'b0) begin errors++; $display("FAIL life_pulse_width got %b want 0", life_lost); end
    vs = 1'b0;
    repeat (4) @(negedge Clk);

    for (int i = 0; i < 119; i++) begin
      tick_frame((i == 20) ? 4'b0011 : 4'b0000, 1'b1);
      if (i == 7) begin
        checks++;
        if (ship_blink !== 1'b1) begin errors++; $display("FAIL blink_cnt8 got %b want 1", ship_blink); end
      end
      if (i == 15) begin
        checks++;
        if (ship_blink !== 1'b0) begin errors++; $display("FAIL blink_cnt16 got %b want 0", ship_blink); end
      end
    end
    checks++;
    if (lives !== 3'd2 || ship_invuln !== 1'b1 || in_play !== 1'b1) begin
      errors++; $display("FAIL invuln_hold got lives %0d invuln %b play %b want 2 1 1", lives, ship_invuln, in_play);
    end
    checks++;
    if (score_bcd !== 16'h0020) begin errors++; $display("FAIL respawn_score got %h want %h", score_bcd, 16'h0020); end
    tick_frame(4'b0000, 1'b0);
    checks++;
    if (ship_invuln !== 1'b0 || in_play !== 1'b1 || lives !== 3'd2) begin
      errors++; $display("FAIL respawn_exit got invuln %b play %b lives %0d want 0 1 2", ship_invuln, in_play, lives);
    end
  endtask

  task automatic test_game_over();
    tick_frame(4'b0000, 1'b1);
    checks++;
    if (lives !== 3'd1 || ship_invuln !== 1'b1) begin errors++; $display("FAIL second_loss got lives %0d invuln %b want 1 1", lives, ship_invuln); end
    repeat (120) tick_frame(4'b0000, 1'b0);
    checks++;
    if (ship_invuln !== 1'b0 || in_play !== 1'b1) begin errors++; $display("FAIL second_exit got invuln %b play %b want 0 1", ship_invuln, in_play); end
    tick_frame(4'b0011, 1'b1);
    checks++;
    if ({in_play, game_over, ship_invuln} !== 3'b010 || lives !== 3'd0) begin
      errors++; $display("FAIL over_entry got flags %b lives %0d want 010 0", {in_play, game_over, ship_invuln}, lives);
    end
    checks++;
    if (score_bcd !== 16'h0030) begin errors++; $display("FAIL over_drain got %h want %h", score_bcd, 16'h0030); end
    tick_frame(4'b1111, 1'b1);
    checks++;
    if (score_bcd !== 16'h0030 || lives !== 3'd0 || game_over !== 1'b1) begin
      errors++; $display("FAIL over_frozen got score %h lives %0d over %b want 0030 0 1", score_bcd, lives, game_over);
    end
    pulse_start();
    checks++;
    if (score_bcd !== 16'h0000 || lives !== 3'd3 || {in_play, game_over} !== 2'b10) begin
      errors++; $display("FAIL restart got score %h lives %0d flags %b want 0000 3 10", score_bcd, lives, {in_play, game_over});
    end
  endtask

  task automatic test_saturation();
    repeat (100) tick_frame(4'b1111, 1'b0);
    checks++;
    if (score_bcd !== 16'h2000) begin errors++; $display("FAIL bcd_carry got %h want %h", score_bcd, 16'h2000); end
    repeat (399) tick_frame(4'b1111, 1'b0);
    checks++;
    if (score_bcd !== 16'h9980) begin errors++; $display("FAIL score_9980 got %h want %h", score_bcd, 16'h9980); end
    tick_frame(4'b0111, 1'b0);
    checks++;
    if (score_bcd !== 16'h9995) begin errors++; $display("FAIL score_9995 got %h want %h", score_bcd, 16'h9995); end
    tick_frame(4'b1111, 1'b0);
    checks++;
    if (score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_9999 got %h want %h", score_bcd, 16'h9999); end
    checks++;
    if (dut.pending_q !== 4'd0) begin errors++; $display("FAIL sat_drain got %0d want 0", dut.pending_q); end
    checks++;
    if (lives !== 3'd3) begin errors++; $display("FAIL sat_lives got %0d want 3", lives); end
  endtask

  task automatic test_reset_mid_add();
    @(negedge Clk); shot_hits = 4'b0111;
    @(negedge Clk); shot_hits = 4'b0000; vs = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if (dut.pending_q !== 4'd3) begin errors++; $display("FAIL mid_pending got %0d want 3", dut.pending_q); end
    Reset_h = 1'b1;
    @(negedge Clk);
    checks++;
    if (score_bcd !== 16'h0000 || dut.pending_q !== 4'd0 || dut.state_q !== IDLE) begin
      errors++; $display("FAIL mid_reset got score %h pending %0d state %0d want 0000 0 0", score_bcd, dut.pending_q, dut.state_q);
    end
    checks++;
    if ({in_play, game_over, ship_invuln, ship_blink, life_lost} !== 5'b00000 || lives !== 3'd3) begin
      errors++; $display("FAIL mid_reset_out got flags %b lives %0d want 00000 3", {in_play, game_over, ship_invuln, ship_blink, life_lost}, lives);
    end
    Reset_h = 1'b0; vs = 1'b0;
    repeat (6) @(negedge Clk);
    checks++;
    if (score_bcd !== 16'h0000 || in_play !== 1'b0) begin
      errors++; $display("FAIL post_reset got score %h play %b want 0000 0", score_bcd, in_play);
    end
  endtask

  initial begin
    Reset_h = 1'b1; vs = 1'b0; start = 1'b0; ship_hit = 1'b0; shot_hits = 4'b0000;
    test_reset();
    test_start();
    test_score_hold();
    test_life_loss();
    test_game_over();
    test_saturation();
    test_reset_mid_add();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
